// File: rtl/ctrl_select_mux.sv
// ctrl_select_mux: for each selector index, forwards exactly one packet (or one beat when
// IF_STREAM=0) from the named AXI-Stream input port to a single registered output.
module ctrl_select_mux #(
    parameter int S_COUNT      = 2,
    parameter int SELECT_WIDTH = $clog2(S_COUNT),
    parameter int DATA_WIDTH   = 512,
    parameter int KEEP_WIDTH   = DATA_WIDTH/8,
    parameter int IF_STREAM    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SELECT_WIDTH-1:0]       s_selector_tdata,
    input  logic                          s_selector_tvalid,
    output logic                          s_selector_tready,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          err_bad_select
);
    typedef enum logic {IDLE = 1'b0, FWD = 1'b1} state_t;

    localparam logic [SELECT_WIDTH:0] PORT_LIMIT = (SELECT_WIDTH+1)'(S_COUNT);

    state_t                  state, state_nxt;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    sel_hs, sel_ok;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [KEEP_WIDTH-1:0]   in_keep;
    logic                    in_last, in_valid;
    logic                    in_rdy, beat_acc, pkt_end;
    logic [DATA_WIDTH-1:0]   data_p1;
    logic [KEEP_WIDTH-1:0]   keep_p1;
    logic                    last_p1, vld_p1;

    assign sel_hs   = s_selector_tvalid && s_selector_tready;
    assign sel_ok   = ({1'b0, s_selector_tdata} < PORT_LIMIT);
    assign in_rdy   = (state == FWD) && (m_axis_tready || !vld_p1);
    assign beat_acc = in_rdy && in_valid;
    assign pkt_end  = beat_acc && ((IF_STREAM == 0) || in_last);

    // Only the latched port is looked at; every other port sees ready=0.
    always_comb begin
        in_data       = '0;
        in_keep       = '0;
        in_last       = 1'b0;
        in_valid      = 1'b0;
        s_axis_tready = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (sel == SELECT_WIDTH'(i)) begin
                in_data          = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                in_keep          = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                in_last          = s_axis_tlast[i];
                in_valid         = s_axis_tvalid[i];
                s_axis_tready[i] = in_rdy;
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        s_selector_tready = 1'b0;
        case (state)
            IDLE: begin
                s_selector_tready = 1'b1;
                if (s_selector_tvalid && sel_ok) state_nxt = FWD;
            end
            FWD: begin
                if (pkt_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sel            <= '0;
            err_bad_select <= 1'b0;
        end else begin
            state <= state_nxt;
            if (sel_hs && sel_ok)  sel <= s_selector_tdata;
            if (sel_hs && !sel_ok) err_bad_select <= 1'b1;
        end
    end

    // Stage p1: one-entry output register; a load in the draining cycle replaces the contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            keep_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (beat_acc) begin
            vld_p1  <= 1'b1;
            data_p1 <= in_data;
            keep_p1 <= in_keep;
            last_p1 <= (IF_STREAM == 0) ? 1'b1 : in_last;
        end else if (m_axis_tready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign m_axis_tdata  = data_p1;
    assign m_axis_tkeep  = keep_p1;
    assign m_axis_tlast  = last_p1;
    assign m_axis_tvalid = vld_p1;

endmodule

// File: tb/tb_ctrl_select_mux.sv
// tb_ctrl_select_mux: scoreboard bench for ctrl_select_mux; unit 0 runs packets (IF_STREAM=1),
// unit 1 runs single beats (IF_STREAM=0), both with three input ports.
module tb_ctrl_select_mux;
    localparam int SC = 3;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int SW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [SW-1:0]    sel_d [2];
    logic             sel_v [2];
    logic             sel_r [2];
    logic [SC*DW-1:0] s_d   [2];
    logic [SC*KW-1:0] s_k   [2];
    logic [SC-1:0]    s_l   [2];
    logic [SC-1:0]    s_v   [2];
    logic [SC-1:0]    s_r   [2];
    logic [DW-1:0]    m_d   [2];
    logic [KW-1:0]    m_k   [2];
    logic             m_l   [2];
    logic             m_v   [2];
    logic             m_r   [2];
    logic             err   [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ctrl_select_mux #(
            .S_COUNT    (SC),
            .DATA_WIDTH (DW),
            .IF_STREAM  ((g == 0) ? 1 : 0)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .s_selector_tdata  (sel_d[g]),
            .s_selector_tvalid (sel_v[g]),
            .s_selector_tready (sel_r[g]),
            .s_axis_tdata      (s_d[g]),
            .s_axis_tkeep      (s_k[g]),
            .s_axis_tlast      (s_l[g]),
            .s_axis_tvalid     (s_v[g]),
            .s_axis_tready     (s_r[g]),
            .m_axis_tdata      (m_d[g]),
            .m_axis_tkeep      (m_k[g]),
            .m_axis_tlast      (m_l[g]),
            .m_axis_tvalid     (m_v[g]),
            .m_axis_tready     (m_r[g]),
            .err_bad_select    (err[g])
        );
    end

    beat_t         src_q [2][SC][$];
    int            resv  [2][SC];
    int            acc_cnt [2][SC];
    logic [SW-1:0] selq  [2][$];
    logic [DW+KW:0] exp_q [2][$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit rst_req  = 1'b1;
    bit lat_en   = 1'b0;
    bit m_rdy [2];
    bit rnd   [2];
    int cur_sel [2];
    bit prev_acc [2];
    bit sel_pend [2];
    bit last_pend [2];
    bit stalled [2];
    logic [DW-1:0] held [2];

    function automatic logic [KW-1:0] kf(logic [DW-1:0] d);
        return d[3:0] ^ d[7:4];
    endfunction

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic push_pkt(int u, int p, int base, int n, bit use_last);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.d = DW'(base + i);
            b.l = use_last && (i == n - 1);
            src_q[u][p].push_back(b);
        end
    endtask

    // Expected output order follows the selector order; each selector claims the next packet of its port.
    task automatic reserve(int u, int p);
        int n = 0;
        for (int k = resv[u][p]; k < src_q[u][p].size(); k++) begin
            beat_t b = src_q[u][p][k];
            exp_q[u].push_back({b.d, kf(b.d), (u == 1) ? 1'b1 : b.l});
            n++;
            if (u == 1 || b.l) break;
        end
        resv[u][p] += n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rst = rst_req;
        for (int u = 0; u < 2; u++) begin
            sel_v[u] = !rst_req && (selq[u].size() > 0);
            sel_d[u] = (selq[u].size() > 0) ? selq[u][0] : '0;
            for (int p = 0; p < SC; p++) begin
                bit gap = rnd[u] && ($urandom_range(0, 3) == 0);
                if (!rst_req && src_q[u][p].size() > 0 && !gap) begin
                    s_v[u][p]             = 1'b1;
                    s_d[u][p*DW +: DW]    = src_q[u][p][0].d;
                    s_k[u][p*KW +: KW]    = kf(src_q[u][p][0].d);
                    s_l[u][p]             = src_q[u][p][0].l;
                end else begin
                    s_v[u][p] = 1'b0;
                end
            end
            m_r[u] = rnd[u] ? 1'($urandom_range(0, 1)) : m_rdy[u];
        end
        @(negedge clk);
        cyc++;
        if (rst_req) begin
            for (int u = 0; u < 2; u++) begin
                exp_q[u].delete();
                for (int p = 0; p < SC; p++) resv[u][p] = 0;
                prev_acc[u]  = 1'b0;
                sel_pend[u]  = 1'b0;
                last_pend[u] = 1'b0;
                stalled[u]   = 1'b0;
            end
            return;
        end
        for (int u = 0; u < 2; u++) begin
            bit sel_hs  = sel_v[u] && sel_r[u];
            bit port_hs = |(s_v[u] & s_r[u]);
            if (prev_acc[u]) check_eq("lat_beat", 64'(m_v[u]), 64'd1);
            if (stalled[u]) check_eq("bp_hold", 64'(m_d[u]), 64'(held[u]));
            if (m_v[u] && !m_r[u]) begin
                check_eq("bp_rdy", 64'(s_r[u]), 64'd0);
                stalled[u] = 1'b1;
                held[u]    = m_d[u];
            end else begin
                stalled[u] = 1'b0;
            end
            if (m_v[u] && m_r[u]) begin
                if (exp_q[u].size() == 0) check_eq("beat_extra", 64'(exp_q[u].size()), 64'd1);
                else check_eq("beat", 64'({m_d[u], m_k[u], m_l[u]}), 64'(exp_q[u].pop_front()));
            end
            if (sel_r[u]) check_eq("idle_rdy", 64'(s_r[u]), 64'd0);
            for (int p = 0; p < SC; p++)
                if (s_r[u][p]) check_eq("rdy_port", 64'(p), 64'(cur_sel[u]));
            if (lat_en && sel_pend[u]) check_eq("lat_sel", 64'(port_hs), 64'd1);
            if (lat_en && last_pend[u] && sel_v[u]) check_eq("lat_gap", 64'(sel_hs), 64'd1);
            sel_pend[u]  = 1'b0;
            last_pend[u] = 1'b0;
            prev_acc[u]  = port_hs;
            for (int p = 0; p < SC; p++) begin
                if (s_v[u][p] && s_r[u][p]) begin
                    beat_t b = src_q[u][p].pop_front();
                    if (resv[u][p] > 0) resv[u][p]--;
                    acc_cnt[u][p]++;
                    if (u == 1 || b.l) last_pend[u] = 1'b1;
                end
            end
            if (sel_hs) begin
                logic [SW-1:0] idx = selq[u].pop_front();
                if (int'(idx) < SC) begin
                    cur_sel[u]  = int'(idx);
                    sel_pend[u] = 1'b1;
                    reserve(u, int'(idx));
                end
            end
        end
    endtask

    task automatic drain(int budget);
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + selq[0].size() + selq[1].size()) > 0
               && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain", 64'(exp_q[0].size() + exp_q[1].size() + selq[0].size() + selq[1].size()), 64'd0);
        repeat (3) tick();
    endtask

    task automatic wait_acc(int u, int p, int target, int budget);
        int n = 0;
        while (acc_cnt[u][p] < target && n < budget) begin
            tick();
            n++;
        end
        check_eq("wait_acc", 64'(acc_cnt[u][p] >= target), 64'd1);
    endtask

    task automatic reset_checks(int u);
        check_eq("rst_sel_rdy", 64'(sel_r[u]), 64'd1);
        check_eq("rst_s_rdy",   64'(s_r[u]),   64'd0);
        check_eq("rst_m_vld",   64'(m_v[u]),   64'd0);
        check_eq("rst_err",     64'(err[u]),   64'd0);
    endtask

    initial begin
        int acc0;
        for (int u = 0; u < 2; u++) begin
            sel_d[u] = '0; sel_v[u] = 1'b0; s_d[u] = '0; s_k[u] = '0;
            s_l[u] = '0; s_v[u] = '0; m_r[u] = 1'b1;
            m_rdy[u] = 1'b1; rnd[u] = 1'b0; cur_sel[u] = -1;
            for (int p = 0; p < SC; p++) begin resv[u][p] = 0; acc_cnt[u][p] = 0; end
        end

        tick();
        rst_req = 1'b0;
        tick();
        for (int u = 0; u < 2; u++) begin
            reset_checks(u);
            check_eq("rst_data", 64'({m_d[u], m_k[u], m_l[u]}), 64'd0);
        end

        // Ordered packets on unit 0, single beats with tlast=0 on unit 1.
        lat_en = 1'b1;
        push_pkt(0, 0, 'hA0, 3, 1'b1);
        push_pkt(0, 1, 'hB0, 2, 1'b1);
        push_pkt(0, 1, 'hC0, 2, 1'b1);
        selq[0].push_back(2'd1); selq[0].push_back(2'd0); selq[0].push_back(2'd1);
        push_pkt(1, 0, 'h10, 1, 1'b0);
        push_pkt(1, 0, 'h11, 1, 1'b0);
        push_pkt(1, 1, 'h20, 1, 1'b0);
        selq[1].push_back(2'd0); selq[1].push_back(2'd0); selq[1].push_back(2'd1);
        drain(200);

        // Output backpressure for five cycles in the middle of a packet.
        lat_en = 1'b0;
        push_pkt(0, 2, 'hD0, 6, 1'b1);
        selq[0].push_back(2'd2);
        wait_acc(0, 2, 2, 50);
        m_rdy[0] = 1'b0;
        acc0 = acc_cnt[0][2];
        repeat (5) tick();
        check_eq("bp_noacc", 64'(acc_cnt[0][2] - acc0), 64'd0);
        m_rdy[0] = 1'b1;
        drain(200);

        // Out-of-range selector is consumed and flagged; the next one forwards normally.
        selq[0].push_back(2'd3);
        tick();
        check_eq("bad_consumed", 64'(selq[0].size()), 64'd0);
        tick();
        check_eq("bad_err", 64'(err[0]), 64'd1);
        check_eq("bad_no_out", 64'(m_v[0]), 64'd0);
        lat_en = 1'b1;
        push_pkt(0, 2, 'hE0, 2, 1'b1);
        selq[0].push_back(2'd2);
        drain(200);
        check_eq("bad_err_sticky", 64'(err[0]), 64'd1);

        // Reset in the middle of a packet; the leftover beats form the next packet from port 0.
        lat_en = 1'b0;
        push_pkt(0, 0, 'hF0, 5, 1'b1);
        selq[0].push_back(2'd0);
        wait_acc(0, 0, acc_cnt[0][0] + 2, 50);
        rst_req = 1'b1;
        tick();
        rst_req = 1'b0;
        tick();
        reset_checks(0);
        lat_en = 1'b1;
        selq[0].push_back(2'd0);
        drain(200);

        // Random ready and valid gaps on both units.
        lat_en = 1'b0;
        rnd[0] = 1'b1; rnd[1] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int u = 0; u < 2; u++) begin
                int p = $urandom_range(0, SC - 1);
                int n = (u == 0) ? $urandom_range(1, 4) : 1;
                push_pkt(u, p, 'h1000 * (u + 1) + 'h10 * i, n, u == 0);
                selq[u].push_back(SW'(p));
            end
        end
        drain(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
